// File: rtl/tour_logic_if.sv
// Start/readback bundle between tour_logic and its consumer (TourCmd or a testbench).
// The fail signal and its modport entries exist only when TOUR_FAIL_EN is defined.
interface tour_logic_if;
    logic       go;
    logic [2:0] x_start;
    logic [2:0] y_start;
    logic [4:0] indx;
    logic [7:0] move;
    logic       done;
`ifdef TOUR_FAIL_EN
    logic       fail;

    modport master (output go, x_start, y_start, indx, input  move, done, fail);
    modport slave  (input  go, x_start, y_start, indx, output move, done, fail);
`else
    modport master (output go, x_start, y_start, indx, input  move, done);
    modport slave  (input  go, x_start, y_start, indx, output move, done);
`endif
endinterface

// File: rtl/tour_logic.sv
// Backtracking knight's-tour solver for a 5x5 board; the 24 one-hot moves are read back via indx.
// Optional feature: define TOUR_FAIL_EN to add a one-cycle fail pulse when the search is exhausted.
module tour_logic #(
    parameter int BOARD_DIM = 5
) (
    input  logic        clk,
    input  logic        rst,
    tour_logic_if.slave bus
);
    localparam int         NUM_MOVES   = BOARD_DIM * BOARD_DIM - 1;
    localparam int         NUM_SQUARES = BOARD_DIM * BOARD_DIM;
    localparam logic [3:0] DIM         = 4'(BOARD_DIM);
    localparam logic [4:0] LAST_IDX    = 5'(NUM_MOVES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        POSSIBLE,
        MAKE_MOVE,
        BACKUP,
        DONE
    } state_t;

    state_t                   state;
    logic [NUM_SQUARES-1:0]   visited;
    logic [7:0]               poss_moves [NUM_MOVES];
    logic [7:0]               last_move  [NUM_MOVES];
    logic [4:0]               move_num;
    logic [2:0]               xx;
    logic [2:0]               yy;
    logic                     done_q;
`ifdef TOUR_FAIL_EN
    logic                     fail_q;
`endif

    logic [7:0] targets;
    logic [7:0] cur_last;
    logic [7:0] cand;
    logic [7:0] pick;
    logic [2:0] pick_k;
    logic [4:0] prev_num;
    logic [2:0] back_k;
    logic [2:0] next_x;
    logic [2:0] next_y;
    logic [2:0] back_x;
    logic [2:0] back_y;
    logic       start_ok;

    // Move offsets as 3-bit two's complement, so xx + step wraps back into range mod 8.
    function automatic logic [2:0] step_dx(input logic [2:0] k);
        case (k)
            3'd0:    step_dx = 3'b111;
            3'd1:    step_dx = 3'b001;
            3'd2:    step_dx = 3'b110;
            3'd3:    step_dx = 3'b110;
            3'd4:    step_dx = 3'b111;
            3'd5:    step_dx = 3'b001;
            3'd6:    step_dx = 3'b010;
            default: step_dx = 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] step_dy(input logic [2:0] k);
        case (k)
            3'd0:    step_dy = 3'b010;
            3'd1:    step_dy = 3'b010;
            3'd2:    step_dy = 3'b001;
            3'd3:    step_dy = 3'b111;
            3'd4:    step_dy = 3'b110;
            3'd5:    step_dy = 3'b110;
            3'd6:    step_dy = 3'b111;
            default: step_dy = 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] oh_index(input logic [7:0] oh);
        oh_index = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (oh[k]) begin
                oh_index = 3'(k);
            end
        end
    endfunction

    function automatic logic [4:0] sq_index(input logic [2:0] x, input logic [2:0] y);
        sq_index = {2'b00, y} * 5'(BOARD_DIM) + {2'b00, x};
    endfunction

    // Sign-extended 4-bit sums turn a step off the low edge into 14/15, so one unsigned compare covers both edges.
    function automatic logic [7:0] legal_targets(input logic [2:0] x, input logic [2:0] y,
                                                 input logic [NUM_SQUARES-1:0] board);
        logic [2:0] dx;
        logic [2:0] dy;
        logic [3:0] tx;
        logic [3:0] ty;
        legal_targets = 8'h00;
        for (int k = 0; k < 8; k++) begin
            dx = step_dx(3'(k));
            dy = step_dy(3'(k));
            tx = {1'b0, x} + {dx[2], dx};
            ty = {1'b0, y} + {dy[2], dy};
            if (tx < DIM && ty < DIM) begin
                legal_targets[k] = ~board[sq_index(tx[2:0], ty[2:0])];
            end
        end
    endfunction

    // Candidate selection: retry strictly above the move last taken at this depth, lowest bit first.
    always_comb begin
        targets  = legal_targets(xx, yy, visited);
        cur_last = last_move[move_num];
        cand     = poss_moves[move_num]
                   & ~((cur_last == 8'h00) ? 8'h00 : (cur_last | (cur_last - 8'd1)));
        pick     = cand & (~cand + 8'd1);
        pick_k   = oh_index(pick);
        next_x   = xx + step_dx(pick_k);
        next_y   = yy + step_dy(pick_k);
        prev_num = (move_num == 5'd0) ? 5'd0 : move_num - 5'd1;
        back_k   = oh_index(last_move[prev_num]);
        back_x   = xx - step_dx(back_k);
        back_y   = yy - step_dy(back_k);
        start_ok = bus.go && (bus.x_start < 3'(BOARD_DIM)) && (bus.y_start < 3'(BOARD_DIM));
    end

    // Search sequencer: one state per cycle, all bookkeeping registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            visited  <= '0;
            move_num <= 5'd0;
            xx       <= 3'd0;
            yy       <= 3'd0;
            for (int i = 0; i < NUM_MOVES; i++) begin
                poss_moves[i] <= 8'h00;
                last_move[i]  <= 8'h00;
            end
`ifdef TOUR_FAIL_EN
            fail_q   <= 1'b0;
`endif
        end else begin
`ifdef TOUR_FAIL_EN
            fail_q <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state  <= INIT;
                        done_q <= 1'b0;
                        xx     <= bus.x_start;
                        yy     <= bus.y_start;
                    end
                end

                INIT: begin
                    visited  <= {{(NUM_SQUARES-1){1'b0}}, 1'b1} << sq_index(xx, yy);
                    move_num <= 5'd0;
                    for (int i = 0; i < NUM_MOVES; i++) begin
                        last_move[i] <= 8'h00;
                    end
                    state    <= POSSIBLE;
                end

                POSSIBLE: begin
                    poss_moves[move_num] <= targets;
                    last_move[move_num]  <= 8'h00;
                    state                <= MAKE_MOVE;
                end

                MAKE_MOVE: begin
                    if (cand != 8'h00) begin
                        last_move[move_num]               <= pick;
                        xx                                <= next_x;
                        yy                                <= next_y;
                        visited[sq_index(next_x, next_y)] <= 1'b1;
                        if (move_num == LAST_IDX) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            move_num <= move_num + 5'd1;
                            state    <= POSSIBLE;
                        end
                    end else begin
                        state <= BACKUP;
                    end
                end

                BACKUP: begin
                    if (move_num == 5'd0) begin
                        state  <= IDLE;
`ifdef TOUR_FAIL_EN
                        fail_q <= 1'b1;
`endif
                    end else begin
                        visited[sq_index(xx, yy)] <= 1'b0;
                        move_num                  <= prev_num;
                        xx                        <= back_x;
                        yy                        <= back_y;
                        state                     <= MAKE_MOVE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.move = (bus.indx < 5'(NUM_MOVES)) ? last_move[bus.indx] : 8'h00;
    assign bus.done = done_q;
`ifdef TOUR_FAIL_EN
    assign bus.fail = fail_q;
`endif

endmodule

// File: tb/tb_tour_logic.sv
// Bench for tour_logic: vector table, directed tour/backtrack/reset sequences and random start
// squares, all checked against a coordinate-based depth-first search kept in the bench.
module tb_tour_logic;
    logic clk = 1'b0;
    logic rst;

    tour_logic_if bus();

    tour_logic dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam int MODEL_CAP  = 1_500_000;
    localparam int RANDOM_CAP = 100_000;

    typedef struct {
        logic       go;
        logic [2:0] x;
        logic [2:0] y;
        logic [4:0] indx;
        logic       exp_done;
        logic [7:0] exp_move;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int mdx[8] = '{-1, 1, -2, -2, -1,  1,  2, 2};
    int mdy[8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

    int         exp_dir [24];
    bit         model_found;
    bit         model_capped;
    int         model_steps;
    logic [7:0] dut_tour  [24];
    logic [7:0] saved_tour[24];
    logic [7:0] tour_22   [24];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic go_v, input logic [2:0] x, input logic [2:0] y);
        @(negedge clk);
        bus.go      = go_v;
        bus.x_start = x;
        bus.y_start = y;
        @(negedge clk);
        bus.go      = 1'b0;
    endtask

    // Plain depth-first search over a 5x5 grid, trying directions 0..7 in order at every depth.
    task automatic model_search(input int sx, input int sy);
        int board[5][5];
        int px[25];
        int py[25];
        int next_try[25];
        int depth;
        int nx;
        int ny;
        bit advanced;
        bit running;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                board[x][y] = 0;
        board[sx][sy] = 1;
        px[0] = sx;
        py[0] = sy;
        next_try[0] = 0;
        depth = 0;
        model_found = 1'b0;
        model_capped = 1'b0;
        model_steps = 0;
        running = 1'b1;
        while (running) begin
            if (model_steps >= MODEL_CAP) begin
                model_capped = 1'b1;
                running = 1'b0;
            end else begin
                model_steps++;
                advanced = 1'b0;
                for (int d = next_try[depth]; d < 8 && !advanced; d++) begin
                    nx = px[depth] + mdx[d];
                    ny = py[depth] + mdy[d];
                    if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5) begin
                        if (board[nx][ny] == 0) begin
                            exp_dir[depth]  = d;
                            next_try[depth] = d + 1;
                            board[nx][ny]   = 1;
                            px[depth + 1]   = nx;
                            py[depth + 1]   = ny;
                            advanced        = 1'b1;
                        end
                    end
                end
                if (advanced) begin
                    depth++;
                    if (depth == 24) begin
                        model_found = 1'b1;
                        running = 1'b0;
                    end else begin
                        next_try[depth] = 0;
                    end
                end else if (depth == 0) begin
                    running = 1'b0;
                end else begin
                    board[px[depth]][py[depth]] = 0;
                    depth--;
                end
            end
        end
    endtask

    task automatic run_search(input logic [2:0] sx, input logic [2:0] sy, input bit inject_mid,
                              input int budget, output int cycles, output int fail_pulses);
        apply_stimulus(1'b1, sx, sy);
        check_output("done_low_after_go", int'(bus.done), 0);
        cycles = 0;
        fail_pulses = 0;
        while (!bus.done && cycles < budget) begin
            if (inject_mid && cycles == 4) begin
                bus.go      = 1'b1;
                bus.x_start = 3'd4;
                bus.y_start = 3'd4;
            end else begin
                bus.go = 1'b0;
            end
            @(negedge clk);
            cycles++;
`ifdef TOUR_FAIL_EN
            if (bus.fail) begin
                fail_pulses++;
            end
`endif
        end
        bus.go = 1'b0;
    endtask

    // Reads the 24 moves, compares them with the model and replays them on an independent board.
    task automatic check_tour(input int sx, input int sy, input string tag);
        bit         seen[25];
        int         x;
        int         y;
        int         k;
        int         covered;
        bit         alive;
        bit         step_ok;
        logic [7:0] mv;
        for (int s = 0; s < 25; s++) seen[s] = 1'b0;
        x = sx;
        y = sy;
        seen[y * 5 + x] = 1'b1;
        covered = 1;
        alive = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.indx = 5'(i);
            #1;
            mv = bus.move;
            dut_tour[i] = mv;
            check_output({tag, "_move_vs_model"}, int'(mv), 1 << exp_dir[i]);
            step_ok = 1'b0;
            if (alive && $countones(mv) == 1) begin
                k = 0;
                for (int b = 0; b < 8; b++) if (mv[b]) k = b;
                x = x + mdx[k];
                y = y + mdy[k];
                if (x >= 0 && x < 5 && y >= 0 && y < 5) begin
                    if (!seen[y * 5 + x]) begin
                        seen[y * 5 + x] = 1'b1;
                        covered++;
                        step_ok = 1'b1;
                    end
                end
            end
            alive = step_ok;
            check_output({tag, "_replay_step"}, int'(step_ok), 1);
        end
        check_output({tag, "_squares_covered"}, covered, 25);
    endtask

    initial begin
        vec_t vecs[6];
        int   cyc_a;
        int   cyc_b;
        int   fails;
        int   budget;
        int   budget_22;
        int   rx;
        int   ry;
        bit   have_22;

        vecs[0] = '{1'b1, 3'd5, 3'd3, 5'd0,  1'b0, 8'h00};
        vecs[1] = '{1'b1, 3'd7, 3'd7, 5'd5,  1'b0, 8'h00};
        vecs[2] = '{1'b1, 3'd0, 3'd5, 5'd23, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 3'd4, 3'd6, 5'd24, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 3'd6, 3'd1, 5'd31, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 3'd2, 3'd2, 5'd12, 1'b0, 8'h00};

        rst = 1'b1;
        bus.go = 1'b0;
        bus.x_start = 3'd0;
        bus.y_start = 3'd0;
        bus.indx = 5'd0;
        have_22 = 1'b0;
        budget_22 = 0;

        repeat (3) @(negedge clk);
        check_output("reset_done", int'(bus.done), 0);
`ifdef TOUR_FAIL_EN
        check_output("reset_fail", int'(bus.fail), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            bus.indx = 5'(i);
            #1;
            check_output("reset_move", int'(bus.move), 0);
        end

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].go, vecs[v].x, vecs[v].y);
            repeat (3) @(negedge clk);
            bus.indx = vecs[v].indx;
            #1;
            check_output("vec_done", int'(bus.done), int'(vecs[v].exp_done));
            check_output("vec_move", int'(bus.move), int'(vecs[v].exp_move));
        end

        model_search(0, 0);
        if (model_capped) begin
            $display("[TB] start (0,0) exceeds the model step cap, sequence skipped");
        end else begin
            budget = 2 * model_steps + 64;
            run_search(3'd0, 3'd0, 1'b0, budget, cyc_a, fails);
            check_output("t00_done", int'(bus.done), int'(model_found));
            if (model_found) begin
                check_tour(0, 0, "t00");
                for (int i = 0; i < 24; i++) saved_tour[i] = dut_tour[i];
                repeat (5) @(negedge clk);
                check_output("t00_done_held", int'(bus.done), 1);
                run_search(3'd0, 3'd0, 1'b0, budget, cyc_b, fails);
                check_output("t00_rerun_done", int'(bus.done), 1);
                for (int i = 0; i < 24; i++) begin
                    bus.indx = 5'(i);
                    #1;
                    check_output("t00_rerun_move", int'(bus.move), int'(saved_tour[i]));
                end
                check_output("t00_rerun_cycles", cyc_b, cyc_a);
                for (int i = 24; i < 32; i++) begin
                    bus.indx = 5'(i);
                    #1;
                    check_output("indx_out_of_range", int'(bus.move), 0);
                end
            end
        end

        model_search(1, 0);
        if (model_capped) begin
            $display("[TB] start (1,0) exceeds the model step cap, sequence skipped");
        end else begin
            budget = 2 * model_steps + 64;
            run_search(3'd1, 3'd0, 1'b0, budget, cyc_a, fails);
            check_output("t10_done", int'(bus.done), int'(model_found));
`ifdef TOUR_FAIL_EN
            check_output("t10_fail_pulses", fails, model_found ? 0 : 1);
`endif
        end

        model_search(2, 2);
        if (model_capped) begin
            $display("[TB] start (2,2) exceeds the model step cap, sequence skipped");
        end else begin
            budget_22 = 2 * model_steps + 64;
            run_search(3'd2, 3'd2, 1'b1, budget_22, cyc_a, fails);
            check_output("t22_done", int'(bus.done), int'(model_found));
            check_output("t22_within_2M", int'(cyc_a <= 2_000_000), 1);
            if (model_found) begin
                check_tour(2, 2, "t22");
                for (int i = 0; i < 24; i++) tour_22[i] = dut_tour[i];
                have_22 = 1'b1;
            end
        end

        apply_stimulus(1'b1, 3'd2, 3'd2);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_mid_done", int'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            bus.indx = 5'(i);
            #1;
            check_output("rst_mid_move", int'(bus.move), 0);
        end
        if (have_22) begin
            model_search(2, 2);
            run_search(3'd2, 3'd2, 1'b0, budget_22, cyc_b, fails);
            check_output("t22_after_rst_done", int'(bus.done), 1);
            check_output("t22_after_rst_cycles", cyc_b, cyc_a);
            for (int i = 0; i < 24; i++) begin
                bus.indx = 5'(i);
                #1;
                check_output("t22_after_rst_move", int'(bus.move), int'(tour_22[i]));
            end
        end

        for (int r = 0; r < 3; r++) begin
            rx = int'($urandom_range(0, 4));
            ry = int'($urandom_range(0, 4));
            model_search(rx, ry);
            if (model_capped || model_steps > RANDOM_CAP) begin
                $display("[TB] random start (%0d,%0d) search too long, skipped", rx, ry);
            end else begin
                budget = 2 * model_steps + 64;
                run_search(3'(rx), 3'(ry), 1'b0, budget, cyc_a, fails);
                check_output("rand_done", int'(bus.done), int'(model_found));
                if (model_found) begin
                    check_tour(rx, ry, "rand");
                end
`ifdef TOUR_FAIL_EN
                check_output("rand_fail_pulses", fails, model_found ? 0 : 1);
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
